// File: rtl/ps2_pkg.sv
// Shared PS/2 protocol constants and the command sequencer state encoding.
package ps2_pkg;

  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_SET_LEDS  = 8'hED;
  localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
  localparam logic [7:0] CMD_ENABLE    = 8'hF4;

  localparam logic [7:0] RSP_ACK       = 8'hFA;
  localparam logic [7:0] RSP_RESEND    = 8'hFE;
  localparam logic [7:0] RSP_SELF_TEST = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OFFER,
    ST_WAIT_LINE_ACK,
    ST_WAIT_RESPONSE,
    ST_WAIT_SELF_TEST,
    ST_FAULT
  } seq_state_e;

endpackage

// File: rtl/ps2_timeout_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module ps2_timeout_timer #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             run,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (run && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/ps2_command_sequencer.sv
// Arbitrates the PS/2 host-to-device command channel between the power-on
// init sequence and LED updates, with per-byte retry and timeout handling.
module ps2_command_sequencer
  import ps2_pkg::*;
#(
  parameter int          RESPONSE_TIMEOUT  = 540000,
  parameter int          SELF_TEST_TIMEOUT = 27000000,
  parameter int          MAX_RETRIES       = 3,
  parameter logic [7:0]  TYPEMATIC_BYTE    = 8'h20
) (
  input  logic       clk,
  input  logic       reset_low,
  input  logic       command_ready,
  output logic       command_valid,
  output logic [7:0] command_byte,
  output logic       command_ack_ready,
  input  logic       command_ack_valid,
  input  logic       command_ack_error,
  input  logic       acknowledge,
  input  logic       resend,
  input  logic       self_test_passed,
  input  logic       set_status,
  input  logic       set_status_caps_lock,
  input  logic       set_status_num_lock,
  input  logic       set_status_scroll_lock,
  output logic       init_done,
  output logic       busy,
  output logic       fault
);

  localparam int TIMER_MAX = (SELF_TEST_TIMEOUT > RESPONSE_TIMEOUT) ? SELF_TEST_TIMEOUT
                                                                    : RESPONSE_TIMEOUT;
  localparam int TW = $clog2(TIMER_MAX + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);

  seq_state_e      state, state_next;
  logic            seq_led, seq_led_next;
  logic [1:0]      idx, idx_next;
  logic [RW-1:0]   retry, retry_next;
  logic            init_done_next, fault_next;
  logic [7:0]      byte_next;
  logic            retry_hit, led_start;
  logic            led_pending;
  logic [2:0]      led_shadow;
  logic            timer_load, timer_run, timer_expired;
  logic [TW-1:0]   timer_value;

  // Inline sequence ROM: init = FF,F3,typematic,F4; LED = ED,data.
  function automatic logic [7:0] rom_byte(input logic led, input logic [1:0] i,
                                          input logic [2:0] shadow);
    if (led) return (i == 2'd0) ? CMD_SET_LEDS : {5'b00000, shadow};
    case (i)
      2'd0:    return CMD_RESET;
      2'd1:    return CMD_TYPEMATIC;
      2'd2:    return TYPEMATIC_BYTE;
      default: return CMD_ENABLE;
    endcase
  endfunction

  ps2_timeout_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .rst_n      (reset_low),
    .load       (timer_load),
    .load_value (timer_value),
    .run        (timer_run),
    .expired    (timer_expired)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next     = state;
    seq_led_next   = seq_led;
    idx_next       = idx;
    retry_next     = retry;
    init_done_next = init_done;
    fault_next     = fault;
    retry_hit      = 1'b0;
    led_start      = 1'b0;
    timer_load     = 1'b0;
    timer_value    = TW'(RESPONSE_TIMEOUT);
    timer_run      = (state == ST_WAIT_RESPONSE) || (state == ST_WAIT_SELF_TEST);

    case (state)
      ST_IDLE: begin
        if (!init_done) begin
          state_next   = ST_OFFER;
          seq_led_next = 1'b0;
          idx_next     = 2'd0;
          retry_next   = '0;
        end else if (led_pending) begin
          state_next   = ST_OFFER;
          seq_led_next = 1'b1;
          idx_next     = 2'd0;
          retry_next   = '0;
          led_start    = 1'b1;
        end
      end
      ST_OFFER: if (command_ready) state_next = ST_WAIT_LINE_ACK;
      ST_WAIT_LINE_ACK: begin
        if (command_ack_valid) begin
          if (command_ack_error) begin
            retry_hit = 1'b1;
          end else begin
            state_next = ST_WAIT_RESPONSE;
            timer_load = 1'b1;
          end
        end
      end
      ST_WAIT_RESPONSE: begin
        if (acknowledge) begin
          if (!seq_led && idx == 2'd0) begin
            // FF's ack is not an advance: retries keep counting across self-test timeouts.
            state_next  = ST_WAIT_SELF_TEST;
            timer_load  = 1'b1;
            timer_value = TW'(SELF_TEST_TIMEOUT);
          end else if (seq_led ? (idx == 2'd1) : (idx == 2'd3)) begin
            state_next = ST_IDLE;
            retry_next = '0;
            if (!seq_led) init_done_next = 1'b1;
          end else begin
            state_next = ST_OFFER;
            idx_next   = idx + 2'd1;
            retry_next = '0;
          end
        end else if (resend || timer_expired) begin
          retry_hit = 1'b1;
        end
      end
      ST_WAIT_SELF_TEST: begin
        if (self_test_passed) begin
          state_next = ST_OFFER;
          idx_next   = 2'd1;
          retry_next = '0;
        end else if (timer_expired) begin
          retry_hit = 1'b1;
        end
      end
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_IDLE;
    endcase

    if (retry_hit) begin
      if (retry < RW'(MAX_RETRIES)) begin
        retry_next = retry + 1'b1;
        state_next = ST_OFFER;
      end else if (seq_led) begin
        retry_next = '0;
        state_next = ST_IDLE;
      end else begin
        state_next = ST_FAULT;
        fault_next = 1'b1;
      end
    end

    byte_next = command_byte;
    if (state_next == ST_OFFER && state != ST_OFFER)
      byte_next = rom_byte(seq_led_next, idx_next, led_shadow);
  end

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state        <= ST_IDLE;
      seq_led      <= 1'b0;
      idx          <= 2'd0;
      retry        <= '0;
      init_done    <= 1'b0;
      fault        <= 1'b0;
      command_byte <= 8'h00;
    end else begin
      state        <= state_next;
      seq_led      <= seq_led_next;
      idx          <= idx_next;
      retry        <= retry_next;
      init_done    <= init_done_next;
      fault        <= fault_next;
      command_byte <= byte_next;
    end
  end

  // A new request wins over a simultaneous start so it is never lost.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      led_pending <= 1'b0;
      led_shadow  <= 3'b000;
    end else if (set_status) begin
      led_pending <= 1'b1;
      led_shadow  <= {set_status_caps_lock, set_status_num_lock, set_status_scroll_lock};
    end else if (led_start) begin
      led_pending <= 1'b0;
    end
  end

  assign command_valid     = (state == ST_OFFER);
  assign command_ack_ready = (state == ST_WAIT_LINE_ACK);
  assign busy              = (state != ST_IDLE) && (state != ST_FAULT);

endmodule

// File: tb/tb_ps2_command_sequencer.sv
// Directed self-checking bench: init, LED coalescing, retries, fault, timeouts, reset.
module tb_ps2_command_sequencer;

  logic       clk = 1'b0;
  logic       reset_low = 1'b0;
  logic       command_ready = 1'b0;
  logic       command_valid;
  logic [7:0] command_byte;
  logic       command_ack_ready;
  logic       command_ack_valid = 1'b0;
  logic       command_ack_error = 1'b0;
  logic       acknowledge = 1'b0;
  logic       resend = 1'b0;
  logic       self_test_passed = 1'b0;
  logic       set_status = 1'b0;
  logic       set_status_caps_lock = 1'b0;
  logic       set_status_num_lock = 1'b0;
  logic       set_status_scroll_lock = 1'b0;
  logic       init_done, busy, fault;

  int total = 0;
  int bad = 0;

  localparam int P_ACK = 0;
  localparam int P_RESEND = 1;
  localparam int P_SELF_TEST = 2;

  always #5 clk = ~clk;

  ps2_command_sequencer #(
    .RESPONSE_TIMEOUT  (40),
    .SELF_TEST_TIMEOUT (60),
    .MAX_RETRIES       (3),
    .TYPEMATIC_BYTE    (8'h20)
  ) dut (
    .clk                    (clk),
    .reset_low              (reset_low),
    .command_ready          (command_ready),
    .command_valid          (command_valid),
    .command_byte           (command_byte),
    .command_ack_ready      (command_ack_ready),
    .command_ack_valid      (command_ack_valid),
    .command_ack_error      (command_ack_error),
    .acknowledge            (acknowledge),
    .resend                 (resend),
    .self_test_passed       (self_test_passed),
    .set_status             (set_status),
    .set_status_caps_lock   (set_status_caps_lock),
    .set_status_num_lock    (set_status_num_lock),
    .set_status_scroll_lock (set_status_scroll_lock),
    .init_done              (init_done),
    .busy                   (busy),
    .fault                  (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for an offer, checks the byte, transfers it and returns line-ack status.
  task automatic send_byte(input logic [7:0] exp, input logic err, input string tag);
    int n = 0;
    @(negedge clk);
    while (!command_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " valid"}, command_valid, 1);
    check({tag, " byte"}, command_byte, exp);
    command_ready = 1'b1;
    @(negedge clk);
    command_ready = 1'b0;
    check({tag, " ack_ready"}, command_ack_ready, 1);
    command_ack_valid = 1'b1;
    command_ack_error = err;
    @(negedge clk);
    command_ack_valid = 1'b0;
    command_ack_error = 1'b0;
  endtask

  task automatic pulse(input int which);
    case (which)
      P_ACK:    acknowledge = 1'b1;
      P_RESEND: resend = 1'b1;
      default:  self_test_passed = 1'b1;
    endcase
    @(negedge clk);
    acknowledge = 1'b0;
    resend = 1'b0;
    self_test_passed = 1'b0;
  endtask

  task automatic set_led(input logic caps, input logic num, input logic scroll);
    set_status = 1'b1;
    set_status_caps_lock = caps;
    set_status_num_lock = num;
    set_status_scroll_lock = scroll;
    @(negedge clk);
    set_status = 1'b0;
  endtask

  task automatic quiet(input int cycles, input string tag);
    logic seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (command_valid) seen = 1'b1;
    end
    check({tag, " no offer"}, seen, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_low = 1'b0;
    repeat (2) @(negedge clk);
    reset_low = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst valid", command_valid, 0);
    check("rst byte", command_byte, 8'h00);
    check("rst ack_ready", command_ack_ready, 0);
    check("rst init_done", init_done, 0);
    check("rst busy", busy, 0);
    check("rst fault", fault, 0);
    reset_low = 1'b1;

    // Clean init; two LED requests land during the F4 wait and must coalesce
    send_byte(8'hFF, 1'b0, "init FF");
    pulse(P_ACK);
    check("self-test wait busy", busy, 1);
    check("self-test wait init_done", init_done, 0);
    pulse(P_SELF_TEST);
    send_byte(8'hF3, 1'b0, "init F3");
    pulse(P_ACK);
    send_byte(8'h20, 1'b0, "init 20");
    pulse(P_ACK);
    send_byte(8'hF4, 1'b0, "init F4");
    set_led(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    set_led(1'b1, 1'b1, 1'b0);
    pulse(P_ACK);
    check("init done", init_done, 1);
    check("init idle busy", busy, 0);
    send_byte(8'hED, 1'b0, "coalesce ED");
    pulse(P_ACK);
    send_byte(8'h06, 1'b0, "coalesce data");
    pulse(P_ACK);
    quiet(10, "coalesce single");
    check("coalesce busy", busy, 0);

    // Request during the data-byte wait triggers a second sequence
    set_led(1'b0, 1'b0, 1'b1);
    send_byte(8'hED, 1'b0, "mid ED1");
    pulse(P_ACK);
    send_byte(8'h01, 1'b0, "mid data1");
    set_led(1'b1, 1'b0, 1'b1);
    pulse(P_ACK);
    send_byte(8'hED, 1'b0, "mid ED2");
    pulse(P_ACK);
    send_byte(8'h05, 1'b0, "mid data2");
    pulse(P_ACK);
    quiet(10, "mid done");

    // Line-level ack error re-offers ED without entering the response wait
    set_led(1'b0, 1'b1, 1'b0);
    send_byte(8'hED, 1'b1, "ackerr ED");
    check("ackerr reoffer valid", command_valid, 1);
    check("ackerr ack_ready", command_ack_ready, 0);
    check("ackerr reoffer byte", command_byte, 8'hED);
    send_byte(8'hED, 1'b0, "ackerr ED retry");
    pulse(P_ACK);
    send_byte(8'h02, 1'b0, "ackerr data");
    pulse(P_ACK);
    quiet(5, "ackerr done");

    // Resend on F3 recovers; four resends on F4 exhaust retries and fault
    do_reset();
    send_byte(8'hFF, 1'b0, "rs FF");
    pulse(P_ACK);
    pulse(P_SELF_TEST);
    send_byte(8'hF3, 1'b0, "rs F3");
    pulse(P_RESEND);
    send_byte(8'hF3, 1'b0, "rs F3 again");
    pulse(P_ACK);
    send_byte(8'h20, 1'b0, "rs 20");
    pulse(P_ACK);
    send_byte(8'hF4, 1'b0, "rs F4 try0");
    for (int i = 1; i <= 3; i++) begin
      pulse(P_RESEND);
      send_byte(8'hF4, 1'b0, $sformatf("rs F4 try%0d", i));
    end
    pulse(P_RESEND);
    check("fault set", fault, 1);
    check("fault busy", busy, 0);
    check("fault init_done", init_done, 0);
    pulse(P_ACK);
    quiet(10, "fault");
    check("fault sticky", fault, 1);

    // Self-test timeout re-sends FF once per timeout
    do_reset();
    send_byte(8'hFF, 1'b0, "st FF");
    pulse(P_ACK);
    quiet(50, "st early1");
    send_byte(8'hFF, 1'b0, "st FF timeout1");
    pulse(P_ACK);
    quiet(50, "st early2");
    send_byte(8'hFF, 1'b0, "st FF timeout2");
    pulse(P_ACK);
    pulse(P_SELF_TEST);

    // Asynchronous reset while F3 is being offered
    @(negedge clk);
    check("pre-reset valid", command_valid, 1);
    check("pre-reset byte", command_byte, 8'hF3);
    reset_low = 1'b0;
    #1;
    check("async reset valid", command_valid, 0);
    check("async reset busy", busy, 0);
    @(negedge clk);
    reset_low = 1'b1;
    send_byte(8'hFF, 1'b0, "post-reset FF");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_command_sequencer.md
Name: ps2_command_sequencer

Overview:
- Owns the PS/2 host-to-device command channel of the protocol layer and shares it between two requesters.
  - Requester 1: the power-on initialisation sequence (reset, typematic rate, enable scanning).
  - Requester 2: keyboard LED updates raised by the keyboard state tracker.
- Sequences multi-byte commands one byte at a time and waits for each device response.
- Retries on resend or timeout, and reports init completion or fault to the rest of the design.

Parameters:
- RESPONSE_TIMEOUT, 540000, clock cycles to wait for FA/FE after a byte is line-acknowledged (20 ms at 27 MHz).
- SELF_TEST_TIMEOUT, 27000000, clock cycles to wait for AA after the FF reset is acknowledged (1 s).
- MAX_RETRIES, 3, resends/timeouts tolerated per byte before giving up.
- TYPEMATIC_BYTE, 8'h20, argument sent after F3.

Ports:
- clk  input  1  system clock
- reset_low  input  1  asynchronous active-low reset
- command_ready  input  1  protocol accepts a command byte this cycle
- command_valid  output  1  command byte offered
- command_byte  output  8  byte to transmit
- command_ack_ready  output  1  sequencer accepts line-level ack status
- command_ack_valid  input  1  line-level ack status present
- command_ack_error  input  1  device did not pull data low in ack bit
- acknowledge  input  1  one-cycle pulse, FA received
- resend  input  1  one-cycle pulse, FE received
- self_test_passed  input  1  one-cycle pulse, AA received
- set_status  input  1  one-cycle LED update request
- set_status_caps_lock  input  1  LED value, sampled with set_status
- set_status_num_lock  input  1  LED value, sampled with set_status
- set_status_scroll_lock  input  1  LED value, sampled with set_status
- init_done  output  1  init sequence completed
- busy  output  1  a command sequence is in progress
- fault  output  1  init failed; sticky until reset

Behaviour:
- Reset values: command_valid=0, command_byte=8'h00, command_ack_ready=0, init_done=0, busy=0, fault=0. LED pending=0, LED shadow=3'b000, retry=0, timer=0.
- Exiting reset, the FSM starts the init sequence immediately.
- Init sequence (ROM):
  - FF, then wait for FA, then wait for AA (SELF_TEST_TIMEOUT).
  - F3 then TYPEMATIC_BYTE, each waiting for FA.
  - F4, waiting for FA.
  - On completion, init_done=1 for the rest of operation.
- LED sequence: ED, wait FA; then byte {5'b0, caps, num, scroll}, wait FA.
- States: IDLE, OFFER, WAIT_LINE_ACK, WAIT_RESPONSE, WAIT_SELF_TEST, FAULT.
- OFFER:
  - Hold command_valid=1 with a stable command_byte until the cycle where command_ready=1 (valid&&ready transfer).
  - Then go to WAIT_LINE_ACK.
- WAIT_LINE_ACK:
  - command_ack_ready=1.
  - On command_ack_valid with error=0, go to WAIT_RESPONSE and load the timer.
  - With error=1, treat as a retry event.
- WAIT_RESPONSE:
  - acknowledge advances to the next byte.
  - After the final FF ack, go to WAIT_SELF_TEST.
  - After the last byte of a sequence, go to IDLE.
  - resend or timer expiry is a retry event.
- WAIT_SELF_TEST:
  - self_test_passed advances.
  - Timer expiry is a retry event, which re-sends FF.
- Retry event:
  - If retry<MAX_RETRIES: retry+1, re-OFFER the same byte.
  - Else, during init: go to FAULT, fault=1, init_done stays 0.
  - Else, during LED: abandon the LED sequence and return to IDLE; the pending flag stays as updated by any later request.
- Retry clears to 0 on every successful byte advance.
- Timer: down-counter, sized by clog2 of the larger timeout; expiry means the counter equals 0 while waiting.
- Arbitration:
  - Init has absolute priority; LED requests are only started from IDLE with init_done=1.
  - set_status always latches into the shadow and sets pending, in any state including init and FAULT. Requests coalesce: only the latest value is sent.
  - Starting an LED sequence clears pending. The LED data byte is taken from the shadow at the time the data byte is offered.
  - A set_status arriving mid-sequence sets pending again, so a second sequence follows.
- Stray acknowledge/resend/self_test_passed pulses in IDLE, OFFER or FAULT are ignored.
- busy=1 in every state except IDLE and FAULT.
- FAULT is terminal; only reset leaves it. command_valid stays 0 there.
- Asynchronous reset mid-transfer drops command_valid in the same cycle reset is asserted, and restarts init after release.

Decomposition:
- Shared package ps2_pkg holds:
  - command constants: CMD_RESET=FF, CMD_SET_LEDS=ED, CMD_TYPEMATIC=F3, CMD_ENABLE=F4;
  - response constants: RSP_ACK=FA, RSP_RESEND=FE, RSP_SELF_TEST=AA;
  - the FSM state enum.
- One sub-module is natural: ps2_timeout_timer (load/run/expired down-counter).
- The sequence ROM stays inline.

Test Plan:
- Clean init: ready always 1, ack no error, pulse FA after each byte and AA after FF -> command bytes FF,F3,20,F4 in order; init_done=1 after the final FA; busy=0.
- Resend: pulse resend after F3 -> F3 offered again, then the sequence continues; after MAX_RETRIES+1=4 resends on the same byte -> fault=1, busy=0, no further command_valid.
- Self-test timeout: no AA within SELF_TEST_TIMEOUT -> FF re-sent exactly once per timeout.
- LED coalescing: after init, set_status caps=1, then 2 cycles later caps=1,num=1 -> single ED then 8'h06. A set_status during the 06 wait -> a second ED sequence follows.
- Line ack error: command_ack_error=1 on ED -> ED re-offered, retry count increments, no response wait entered.
- Reset mid-OFFER: assert reset_low=0 while command_valid=1 -> command_valid=0 immediately; after release, FF offered again.
